// File: rtl/regfile_wb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_pkg
// Shared types and constants for the architectural integer register file:
// register address/data widths, the hard-wired zero register, and a small
// address-match helper used by the read-bypass and scoreboard logic.
// -----------------------------------------------------------------------------
package regfile_wb_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]      reg_data_t;

    // x0 is hard-wired to zero and never tracked.
    localparam reg_addr_t ZERO_REG = 5'd0;

    // True when an enabled access targets address b and b is not x0.
    function automatic logic addr_hit(input logic en, input reg_addr_t a, input reg_addr_t b);
        return en && (a == b) && (b != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_if
// Bundles the writeback, read, issue/cancel and status signals of regfile_wb.
//   master : pipeline side (drives writeback, reads, issue, cancel)
//   slave  : register file side (returns read data, stall, scoreboard full)
// Signal suffixes (_i/_o) are from the register file's point of view.
// -----------------------------------------------------------------------------
interface regfile_wb_if;
    import regfile_wb_pkg::*;

    logic      write_i;
    reg_addr_t regw_addr_i;
    reg_data_t regw_data_i;
    logic      re1_i;
    reg_addr_t raddr1_i;
    logic      re2_i;
    reg_addr_t raddr2_i;
    reg_data_t rdata1_o;
    reg_data_t rdata2_o;
    logic      issue_i;
    reg_addr_t issue_addr_i;
    logic      cancel_i;
    reg_addr_t cancel_addr_i;
    logic      stall_o;
    logic      sb_full_o;

    modport master (
        output write_i, regw_addr_i, regw_data_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        output issue_i, issue_addr_i, cancel_i, cancel_addr_i,
        input  rdata1_o, rdata2_o, stall_o, sb_full_o
    );

    modport slave (
        input  write_i, regw_addr_i, regw_data_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        input  issue_i, issue_addr_i, cancel_i, cancel_addr_i,
        output rdata1_o, rdata2_o, stall_o, sb_full_o
    );

endinterface

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Pending-write scoreboard: one CNT_W-bit counter per architectural register.
// Each edge a counter moves by (issue - writeback - cancel) in a single step,
// clamped at 0; an increment that would overflow is dropped.
// Ports:
//   clock, reset          clock / asynchronous active-high reset
//   inc_i/inc_addr_i      issue of a write to a register
//   wb_i/wb_addr_i        writeback of a register
//   cancel_i/_addr_i      squash of a previously issued write
//   rdN_en_i/rdN_addr_i   read source lookups
//   pendingN_o            source N has a write in flight
//   full_o                counter of inc_addr_i is saturated
// Optional: REGFILE_BYPASS_EN lets a same-cycle writeback retire one count
// for the pending lookup.
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_wb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      inc_i,
    input  reg_addr_t inc_addr_i,
    input  logic      wb_i,
    input  reg_addr_t wb_addr_i,
    input  logic      cancel_i,
    input  reg_addr_t cancel_addr_i,
    input  logic      rd1_en_i,
    input  reg_addr_t rd1_addr_i,
    input  logic      rd2_en_i,
    input  reg_addr_t rd2_addr_i,
    output logic      pending1_o,
    output logic      pending2_o,
    output logic      full_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    // Net update of one counter: an increment cancels one decrement first,
    // remaining decrements clamp at zero, a pure increment at max is dropped.
    function automatic logic [CNT_W-1:0] next_cnt(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec_a,
        input logic             dec_b
    );
        logic [1:0]       dec_n;
        logic [CNT_W+1:0] cnt_w;
        logic [CNT_W+1:0] dec_w;
        dec_n = {1'b0, dec_a} + {1'b0, dec_b};
        if (inc) begin
            if (dec_n == 2'd0)
                return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            dec_n = dec_n - 2'd1;
        end
        cnt_w = {2'b00, cnt};
        dec_w = {{CNT_W{1'b0}}, dec_n};
        if (cnt_w <= dec_w)
            return '0;
        return CNT_W'(cnt_w - dec_w);
    endfunction

    // NOTE: every always_comb output gets a default before any condition, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = next_cnt(cnt_q[r],
                                inc_i    && (inc_addr_i    == reg_addr_t'(r)),
                                wb_i     && (wb_addr_i     == reg_addr_t'(r)),
                                cancel_i && (cancel_addr_i == reg_addr_t'(r)));
        end
    end

    // NOTE: the counter array is reset explicitly (not left to power-up
    // contents) because a reset must drop every in-flight write at once.
    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        pending1_o = rd1_en_i && (rd1_addr_i != ZERO_REG) && (cnt_q[rd1_addr_i] != '0);
        pending2_o = rd2_en_i && (rd2_addr_i != ZERO_REG) && (cnt_q[rd2_addr_i] != '0);
`ifdef REGFILE_BYPASS_EN
        // The writeback landing this cycle is forwarded, so it retires one count.
        if (addr_hit(wb_i, wb_addr_i, rd1_addr_i))
            pending1_o = rd1_en_i && (cnt_q[rd1_addr_i] > CNT_W'(1));
        if (addr_hit(wb_i, wb_addr_i, rd2_addr_i))
            pending2_o = rd2_en_i && (cnt_q[rd2_addr_i] > CNT_W'(1));
`endif
        full_o = (inc_addr_i != ZERO_REG) && (cnt_q[inc_addr_i] == CNT_MAX);
    end

endmodule

// File: rtl/regfile_wb.sv
// -----------------------------------------------------------------------------
// regfile_wb
// Architectural integer register file at the end of the memory/writeback
// pipeline register. One writeback per cycle, two combinational read ports,
// and a per-register pending-write scoreboard driving a decode stall.
// Ports:
//   clock  system clock (rising edge)
//   reset  asynchronous active-high; clears registers and counters
//   bus    regfile_wb_if.slave: writeback, reads, issue/cancel, stall/full
// Parameter CNT_W: width of each pending counter (max 2**CNT_W-1 in flight).
// Optional: define REGFILE_BYPASS_EN to forward same-cycle writeback data to
// the read ports and resolve the last pending write in its writeback cycle.
// -----------------------------------------------------------------------------
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    regfile_wb_if.slave bus
);

    reg_data_t regs_q [NUM_REGS];
    reg_data_t regs_d [NUM_REGS];
    reg_data_t rdata1;
    reg_data_t rdata2;
    logic      pending1;
    logic      pending2;
    logic      sb_full;

    always_comb begin
        regs_d = regs_q;
        if (bus.write_i && (bus.regw_addr_i != ZERO_REG))
            regs_d[bus.regw_addr_i] = bus.regw_data_i;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (bus.re1_i && (bus.raddr1_i != ZERO_REG))
            rdata1 = regs_q[bus.raddr1_i];
        if (bus.re2_i && (bus.raddr2_i != ZERO_REG))
            rdata2 = regs_q[bus.raddr2_i];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed under reset so reads stay zero while held.
        if (!reset && bus.re1_i && addr_hit(bus.write_i, bus.regw_addr_i, bus.raddr1_i))
            rdata1 = bus.regw_data_i;
        if (!reset && bus.re2_i && addr_hit(bus.write_i, bus.regw_addr_i, bus.raddr2_i))
            rdata2 = bus.regw_data_i;
`endif
    end

    regfile_sb #(.CNT_W(CNT_W)) u_sb (
        .clock         (clock),
        .reset         (reset),
        .inc_i         (bus.issue_i),
        .inc_addr_i    (bus.issue_addr_i),
        .wb_i          (bus.write_i),
        .wb_addr_i     (bus.regw_addr_i),
        .cancel_i      (bus.cancel_i),
        .cancel_addr_i (bus.cancel_addr_i),
        .rd1_en_i      (bus.re1_i),
        .rd1_addr_i    (bus.raddr1_i),
        .rd2_en_i      (bus.re2_i),
        .rd2_addr_i    (bus.raddr2_i),
        .pending1_o    (pending1),
        .pending2_o    (pending2),
        .full_o        (sb_full)
    );

    assign bus.rdata1_o  = rdata1;
    assign bus.rdata2_o  = rdata2;
    assign bus.stall_o   = pending1 | pending2;
    assign bus.sb_full_o = sb_full;

endmodule
